// File: rtl/pc_fetch_pkg.sv
// Shared definitions for the PC fetch unit: FSM state encoding, reset vector,
// MIPS-style opcode/func constants and the packed control-flag bundle.
// Latency: n/a (definitions only). Backpressure: n/a.
package pc_fetch_pkg;

    // Fetch FSM states
    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_REQ     = 3'd1,
        ST_HOLD    = 3'd2,
        ST_RESOLVE = 3'd3,
        ST_HALT    = 3'd4
    } fetch_state_t;

    // First fetch address after reset unless overridden at instantiation
    localparam logic [31:0] RESET_VECTOR_DEF = 32'h0000_0000;

    // Opcode / func field values of the control-flow instructions
    localparam logic [5:0] OP_J    = 6'b000010;
    localparam logic [5:0] OP_JAL  = 6'b000011;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_BNEQ = 6'b000101;
    localparam logic [5:0] FUNC_JR = 6'b001000;

    // Resolved control outcome for the held instruction
    typedef struct packed {
        logic jr;
        logic jump;
        logic branch;
        logic bneq;
        logic zero;
    } ctrl_flags_t;

    // Word offset of a conditional branch, sign-extended and scaled to bytes
    function automatic logic [31:0] branch_offset(input logic [15:0] imm);
        return {{14{imm[15]}}, imm, 2'b00};
    endfunction

    // Pseudo-direct jump target: top nibble comes from the delay-slot-free PC+4
    function automatic logic [31:0] jump_target(input logic [31:0] pc_plus4,
                                                input logic [25:0] idx);
        return {pc_plus4[31:28], idx, 2'b00};
    endfunction

endpackage

// File: rtl/next_pc_sel.sv
// Combinational next-PC selector: jr > jump > taken branch > sequential PC+4.
// Latency: 0 cycles (pure combinational). Backpressure: none, no handshake.
// Ports: i_pc_plus4 (PC+4 of held instr), i_instr_idx (instr[25:0]),
//        i_jr_target (rs value), i_ctrl (resolved flags), o_next_pc.
module next_pc_sel
    import pc_fetch_pkg::*;
(
    input  logic [31:0] i_pc_plus4,
    input  logic [25:0] i_instr_idx,
    input  logic [31:0] i_jr_target,
    input  ctrl_flags_t i_ctrl,
    output logic [31:0] o_next_pc
);

    logic        w_br_taken;
    logic [31:0] w_br_target;
    logic [31:0] w_jmp_target;

    // beq takes the branch on Zero, bneq on !Zero
    assign w_br_taken   = i_ctrl.branch & (i_ctrl.zero ^ i_ctrl.bneq);
    // 32-bit adder wraps modulo 2^32 by construction
    assign w_br_target  = i_pc_plus4 + branch_offset(i_instr_idx[15:0]);
    assign w_jmp_target = jump_target(i_pc_plus4, i_instr_idx);

    always_comb begin
        o_next_pc = i_pc_plus4;
        if (i_ctrl.jr) begin
            o_next_pc = i_jr_target;
        end else if (i_ctrl.jump) begin
            o_next_pc = w_jmp_target;
        end else if (w_br_taken) begin
            o_next_pc = w_br_target;
        end
    end

endmodule

// File: rtl/pc_fetch.sv
// Instruction fetch unit: one-outstanding fetch FSM holding the PC, the fetched
// word and its PC+4 until decode accepts it and the control outcome resolves.
// Latency: 1 cycle IDLE->REQ, >=1 cycle in REQ until imem_ack, then HOLD.
// Backpressure: REQ waits on imem_ack, HOLD waits on instr_ready, RESOLVE on resolve_valid.
// Ports: clk, rst_n (sync, active-low); imem_req/imem_addr/imem_ack/imem_rdata to
//        instruction memory; instr/instr_valid/instr_ready/pc_plus4 to decode;
//        resolve_valid + Branch/Bneq/Jump/Jr/Zero/jr_target from control; fault sticky.
module pc_fetch
    import pc_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_VECTOR = RESET_VECTOR_DEF
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instr,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [31:0] pc_plus4,
    input  logic        resolve_valid,
    input  logic        Branch,
    input  logic        Bneq,
    input  logic        Jump,
    input  logic        Jr,
    input  logic        Zero,
    input  logic [31:0] jr_target,
    output logic        fault
);

    fetch_state_t r_state;
    logic [31:0]  r_pc;
    logic [31:0]  r_instr;
    logic [31:0]  r_pc_plus4;
    logic         r_instr_valid;
    logic         r_imem_req;
    logic         r_fault;

    ctrl_flags_t  w_ctrl;
    logic [31:0]  w_next_pc;
    logic [31:0]  w_seq_pc;
    logic         w_misaligned;

    assign w_ctrl = '{jr: Jr, jump: Jump, branch: Branch, bneq: Bneq, zero: Zero};
    assign w_seq_pc = r_pc + 32'd4;

    next_pc_sel u_next_pc_sel (
        .i_pc_plus4  (r_pc_plus4),
        .i_instr_idx (r_instr[25:0]),
        .i_jr_target (jr_target),
        .i_ctrl      (w_ctrl),
        .o_next_pc   (w_next_pc)
    );

    assign w_misaligned = |w_next_pc[1:0];

    // All outputs come straight from flops, so nothing changes between edges.
    // imem_req is only raised on entry to REQ and dropped on the ack, which
    // keeps at most one fetch in flight.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state       <= ST_IDLE;
            r_pc          <= RESET_VECTOR;
            r_instr       <= 32'h0;
            r_pc_plus4    <= 32'h0;
            r_instr_valid <= 1'b0;
            r_imem_req    <= 1'b0;
            r_fault       <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_imem_req <= 1'b1;
                    r_state    <= ST_REQ;
                end
                ST_REQ: begin
                    if (imem_ack) begin
                        r_instr       <= imem_rdata;
                        r_pc_plus4    <= w_seq_pc;
                        r_imem_req    <= 1'b0;
                        r_instr_valid <= 1'b1;
                        r_state       <= ST_HOLD;
                    end
                end
                ST_HOLD: begin
                    // resolve_valid is deliberately not looked at here; the
                    // outcome is only sampled once RESOLVE is reached.
                    if (instr_ready) begin
                        r_instr_valid <= 1'b0;
                        r_state       <= ST_RESOLVE;
                    end
                end
                ST_RESOLVE: begin
                    if (resolve_valid) begin
                        if (w_misaligned) begin
                            // PC keeps the faulting instruction's address
                            r_fault <= 1'b1;
                            r_state <= ST_HALT;
                        end else begin
                            r_pc       <= w_next_pc;
                            r_imem_req <= 1'b1;
                            r_state    <= ST_REQ;
                        end
                    end
                end
                ST_HALT: begin
                    r_imem_req    <= 1'b0;
                    r_instr_valid <= 1'b0;
                end
                default: begin
                    r_imem_req    <= 1'b0;
                    r_instr_valid <= 1'b0;
                    r_state       <= ST_IDLE;
                end
            endcase
        end
    end

    assign imem_req    = r_imem_req;
    assign imem_addr   = r_pc;
    assign instr       = r_instr;
    assign instr_valid = r_instr_valid;
    assign pc_plus4    = r_pc_plus4;
    assign fault       = r_fault;

endmodule

// File: doc/pc_fetch.md
PC_FETCH -- requirements
Module: pc_fetch

Interface
REQ-001 SHALL have parameter RESET_VECTOR, default 32'h0000_0000, meaning first fetch address after reset.
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port rst_n  input  1  reset; one clock; reset is synchronous and active-low.
REQ-004 SHALL have port imem_req  output  1  instruction-memory read request.
REQ-005 SHALL have port imem_addr  output  32  word-aligned fetch address (the PC).
REQ-006 SHALL have port imem_ack  input  1  memory returns imem_rdata this cycle.
REQ-007 SHALL have port imem_rdata  input  32  fetched instruction word.
REQ-008 SHALL have port instr  output  32  held instruction to decode/main control.
REQ-009 SHALL have port instr_valid  output  1  instr and pc_plus4 valid.
REQ-010 SHALL have port instr_ready  input  1  decode accepts instr.
REQ-011 SHALL have port pc_plus4  output  32  PC+4 of held instr; the jal link value.
REQ-012 SHALL have port resolve_valid  input  1  control/ALU outcome for held instr present.
REQ-013 SHALL have ports Branch, Bneq, Jump, Jr, Zero  input  1 each  resolved control flags plus ALU zero.
REQ-014 SHALL have port jr_target  input  32  rs value for jr.
REQ-015 SHALL have port fault  output  1  sticky misaligned-target flag.

Function
REQ-016 SHALL implement states IDLE, REQ, HOLD, RESOLVE, HALT.
REQ-017 IDLE: entered on reset; next cycle -> REQ.
REQ-018 REQ: imem_req=1, imem_addr=PC; on imem_ack capture imem_rdata into instr, pc_plus4=PC+4, -> HOLD; without ack stay in REQ with address stable.
REQ-019 HOLD: instr_valid=1; on instr_ready -> RESOLVE; instr/pc_plus4 stable while in HOLD.
REQ-020 RESOLVE: instr_valid=0; wait for resolve_valid, then load next PC and -> REQ (or HALT, REQ-023).
REQ-021 Next PC priority: Jr -> jr_target; else Jump -> {pc_plus4[31:28], instr[25:0], 2'b00}; else Branch & (Zero XOR Bneq) -> pc_plus4 + (sign-extended instr[15:0] << 2); else pc_plus4.
REQ-022 Arithmetic SHALL be 32-bit modulo 2^32; PC 32'hFFFF_FFFC + 4 wraps to 0 without a fault.
REQ-023 Selected next PC with bits[1:0] != 0: set fault=1, -> HALT; PC not updated.
REQ-024 HALT: imem_req=0, instr_valid=0; held until reset.
REQ-025 imem_ack outside REQ SHALL be ignored.
REQ-026 resolve_valid outside RESOLVE SHALL be ignored.
REQ-027 instr_ready and resolve_valid both high in HOLD: only HOLD->RESOLVE; resolve sampled from the next cycle.
REQ-028 At most one fetch SHALL be outstanding at any time.

Reset
REQ-029 rst_n=0 at a clock edge: state=IDLE, PC=RESET_VECTOR, instr=0, pc_plus4=0, instr_valid=0, imem_req=0, fault=0.
REQ-030 Reset mid-fetch (REQ with pending ack) SHALL abandon the fetch; a later ack is ignored until REQ is re-entered.
REQ-031 No output SHALL change asynchronously to clk.

Structure
REQ-032 State encoding, RESET_VECTOR default, and opcode/func constants (000010 j, 000011 jal, 000100 beq, 000101 bneq, func 001000 jr) SHALL reside in a shared package.
REQ-033 Next-PC selection SHALL be one combinational sub-module, next_pc_sel.

Verification
REQ-034 Reset release, ack on 2nd REQ cycle with 32'h2002_0005 -> imem_addr=0, instr=32'h2002_0005, pc_plus4=4, next imem_addr=4.
REQ-035 PC=0x10, beq, imm=16'hFFFE, Zero=1 -> next imem_addr=0x0C; Zero=0 -> 0x14.
REQ-036 PC=0x10, Bneq=1, Branch=1, Zero=0, imm=3 -> next imem_addr=0x20.
REQ-037 PC=0x40, Jump=1, instr[25:0]=26'h100 -> 0x400; Jr=1 and Jump=1 with jr_target=0x80 -> 0x80.
REQ-038 Jr, jr_target=0x82 -> fault=1, imem_req=0 for 10 cycles; rst_n low one edge -> fault=0, imem_addr=0.
REQ-039 instr_ready low 5 cycles in HOLD -> instr stable, no new imem_req; ack during HOLD ignored.
